aes_inv_cipher: RTL and testbench
=================================

# aes_inv_cipher

Iterative AES-128 decryption core: the inverse of the encryption round datapath, turning a 128-bit ciphertext and a 128-bit cipher key into plaintext over multiple clock cycles. It is built from the codebase's forward `sbox`, which it uses for key schedule SubWord, plus new inverse S-box, InvShiftRows and InvMixColumns logic. Control uses a start/busy/done handshake so a host controller or testbench can drive it.

## Interface
- No parameters; AES-128 only, Nr = 10.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `ct_in` input [0:127]: ciphertext; byte k = `ct_in[8k +: 8]`; column-major state (bytes 0-3 = column 0).
- `key_in` input [0:127]: cipher key (round key 0), same byte order.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when `pt_out` is updated.
- `pt_out` output [0:127]: plaintext, registered, held until the next `done`.

## Operation
- Registers:
  - `st` [0:127]: state.
  - `rk` [0:127]: current round key.
  - `cnt` 4-bit: round counter.
  - FSM: IDLE, KEXP, INIT, ROUND, FINAL.
- **IDLE**
  - `busy=0`.
  - On `start=1`: `st<=ct_in`, `rk<=key_in`, `cnt<=1`, go to KEXP.
- **KEXP** (10 cycles): forward key expansion.
  - `rk<=next(rk, Rcon[cnt])`, where w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00} and wi' = wi ^ w(i-1)' for i = 1..3.
  - `cnt` increments; leave KEXP when `cnt==10` (`rk` = k10).
- **INIT**
  - `st<=st^rk`; `rk<=prev(rk, Rcon[10])`, giving k9.
  - `cnt<=9`.
- **prev(k, Rcon[r])** (inverse key step):
  - w3 = k3^k2; w2 = k2^k1; w1 = k1^k0.
  - w0 = k0 ^ SubWord(RotWord(w3)) ^ {Rcon[r],00,00,00}, with Rcon indexed by the round being undone.
- **ROUND** (`cnt` 9 down to 1, 9 cycles):
  - `st<=InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk)`.
  - `rk<=prev(rk, Rcon[cnt])`; `cnt` decrements.
  - After `cnt==1`, go to FINAL (`rk` = k0).
- **FINAL**
  - `pt_out<=InvSubBytes(InvShiftRows(st)) ^ rk`.
  - `done<=1`; go to IDLE.
- Arithmetic:
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, from a constant lookup on `cnt`.
  - InvMixColumns uses the GF(2^8) multiplier set {0e,0b,0d,09}, reduced by 0x11b.
- InvShiftRows: row r of the state is rotated right by r columns.
- `start` while `busy=1` is ignored. Inputs are not re-sampled mid-operation, so `ct_in` and `key_in` may change after the accept cycle.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy=0`, `done=0`, `pt_out=0`.
  - `st`, `rk` and `cnt` = 0.
- Accept edge E (IDLE with `start=1`): `busy=1` from E; KEXP occupies edges E+1..E+10.
- INIT at E+11, ROUND at E+12..E+20, FINAL at E+21.
- `done=1` and the new `pt_out` are visible after E+21, for exactly one cycle; `busy=0` in that same cycle.
- Latency 21 cycles. Throughput: one block per 22 cycles, since the next `start` can be accepted at the edge ending the `done` cycle (E+22).
- `start` held high continuously: back-to-back operations, with one IDLE accept cycle between them.
- `rst` asserted mid-operation: immediate return to reset values; `done` does not pulse; the aborted block is discarded.
- `rst` released with `start=1` already high: accepted on the first edge after release.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: pt 00112233445566778899aabbccddeeff, with `done` exactly 21 edges after accept.
  - Required: internal `rk` at INIT = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Required: pt 3243f6a8885a308d313198a2e0370734; `rk` after KEXP = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Busy-ignore:
  - Stimulus: run C.1, then pulse `start` with vector B inputs at E+5.
  - Required: the C.1 result only; a single `done`; `pt_out` unchanged afterwards.
- Back-to-back:
  - Stimulus: `start` held high with C.1 then B inputs.
  - Required: two `done` pulses 22 cycles apart with the correct plaintexts; `pt_out` holds the first result between them.
- Reset mid-op:
  - Stimulus: assert `rst` at E+15 between edges.
  - Required: `busy`, `done` and `pt_out` go to 0 asynchronously; no `done`; a subsequent C.1 run gives the correct result.
- Round-trip:
  - Stimulus: 100 random key/plaintext pairs encrypted by the reference encryption model, then fed to the core.
  - Required: the original plaintext is recovered each time.

Source files
------------

// File: rtl/aes_inv_cipher_if.sv
// aes_inv_cipher_if: start/busy/done handshake bundle for the AES-128 decryption core
interface aes_inv_cipher_if;
  logic         start;
  logic [0:127] ct_in;
  logic [0:127] key_in;
  logic         busy;
  logic         done;
  logic [0:127] pt_out;
  modport master (output start, ct_in, key_in, input busy, done, pt_out);
  modport slave  (input start, ct_in, key_in, output busy, done, pt_out);
endinterface

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, forward key expansion then on-the-fly inverse key schedule
module aes_inv_cipher (
  input  logic clk,
  input  logic rst,
  aes_inv_cipher_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_t;
  state_t       state_q, state_d;
  logic [0:127] st_q, st_d, rk_q, rk_d, pt_q, pt_d, sb_sr;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse and conveniently maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [0:127] key_next(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[0:31] ^ sub_rot(k[96:127]) ^ {rc, 24'h0};
    w1 = k[32:63] ^ w0;
    w2 = k[64:95] ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // undo one expansion step: recover the previous words first, then w0 from the recovered w3
  function automatic logic [0:127] key_prev(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[96:127] ^ k[64:95];
    w2 = k[64:95] ^ k[32:63];
    w1 = k[32:63] ^ k[0:31];
    w0 = k[0:31] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [0:127] inv_sr_sb(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = inv_sbox(s[8*(r+4*((c+4-r)%4)) +: 8]);
    return o;
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign sb_sr      = inv_sr_sb(st_q);
  assign bus.busy   = state_q != IDLE;
  assign bus.done   = done_q;
  assign bus.pt_out = pt_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        st_d    = bus.ct_in;
        rk_d    = bus.key_in;
        cnt_d   = 4'd1;
        state_d = KEXP;
      end
      KEXP: begin
        rk_d    = key_next(rk_q, rcon(cnt_q));
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd10 ? INIT : KEXP;
      end
      INIT: begin
        st_d    = st_q ^ rk_q;
        rk_d    = key_prev(rk_q, rcon(4'd10));
        cnt_d   = 4'd9;
        state_d = ROUND;
      end
      ROUND: begin
        st_d    = inv_mix(sb_sr ^ rk_q);
        rk_d    = key_prev(rk_q, rcon(cnt_q));
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? FINAL : ROUND;
      end
      FINAL: begin
        pt_d    = sb_sr ^ rk_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher: vector table, handshake corner cases and random round-trips against an AES encryption model
module tb_aes_inv_cipher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_inv_cipher_if bus ();
  aes_inv_cipher dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] k10;
  } vec_t;
  vec_t vecs [3];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] rk, o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
        if (r < 10)
          for (int c = 0; c < 4; c++) begin
            for (int q = 0; q < 4; q++) a[q] = s[4*c+q];
            for (int q = 0; q < 4; q++)
              s[4*c+q] = xt(a[q]) ^ xt(a[(q+1)%4]) ^ a[(q+1)%4] ^ a[(q+2)%4] ^ a[(q+3)%4];
          end
      end
      rk = round_key(key, r);
      for (int k = 0; k < 16; k++) s[k] ^= rk[127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // call right after the accept edge (+1); counts edges until done
  task automatic wait_done(output logic [127:0] p, output int lat, output logic [127:0] k10, output logic b);
    lat = 0;
    k10 = '0;
    p = '0;
    b = 1'b1;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) k10 = dut.rk_q;
      if (bus.done) break;
    end
    p = bus.pt_out;
    b = bus.busy;
  endtask

  task automatic do_op(input logic [127:0] k, input logic [127:0] c, output logic [127:0] p,
                       output int lat, output logic [127:0] k10, output logic b);
    @(negedge clk);
    bus.key_in = k;
    bus.ct_in = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(p, lat, k10, b);
  endtask

  logic [127:0] p, p1, p2, hold, k10, key, pt;
  logic b;
  int lat, ndone, t1, t2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.ct_in = '0;
    bus.key_in = '0;
    build_sbox();
    vecs[0] = '{C1_KEY, C1_CT, C1_PT, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[1] = '{B_KEY, B_CT, B_PT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, round_key(128'h0, 10)};

    repeat (2) @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'h0);
    check("rst_done", 128'(bus.done), 128'h0);
    check("rst_pt", bus.pt_out, 128'h0);
    check("rst_st", dut.st_q, 128'h0);
    check("rst_rk", dut.rk_q, 128'h0);
    check("rst_cnt", 128'(dut.cnt_q), 128'h0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      do_op(vecs[i].key, vecs[i].ct, p, lat, k10, b);
      check($sformatf("vec%0d_pt", i), p, vecs[i].pt);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd21);
      check($sformatf("vec%0d_rk_init", i), k10, vecs[i].k10);
      check($sformatf("vec%0d_busy_at_done", i), 128'(b), 128'h0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_one_cycle", i), 128'(bus.done), 128'h0);
      check($sformatf("vec%0d_pt_held", i), bus.pt_out, vecs[i].pt);
    end

    // start pulsed mid-operation with other inputs must be ignored
    @(negedge clk);
    bus.key_in = C1_KEY;
    bus.ct_in = C1_CT;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    t1 = 0;
    p1 = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) begin
        bus.key_in = B_KEY;
        bus.ct_in = B_CT;
        bus.start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == 5) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        t1 = i;
        p1 = bus.pt_out;
      end
    end
    check("ign_done_count", 128'(ndone), 128'd1);
    check("ign_done_time", 128'(t1), 128'd21);
    check("ign_pt", p1, C1_PT);
    check("ign_pt_after", bus.pt_out, C1_PT);

    // start held high: second block accepted in the done cycle's closing edge
    @(negedge clk);
    bus.key_in = C1_KEY;
    bus.ct_in = C1_CT;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.key_in = B_KEY;
    bus.ct_in = B_CT;
    t1 = 0;
    t2 = 0;
    p1 = '0;
    p2 = '0;
    hold = '0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (i == 22) bus.start = 1'b0;
      if (bus.done) begin
        if (t1 == 0) begin
          t1 = i;
          p1 = bus.pt_out;
        end else begin
          t2 = i;
          p2 = bus.pt_out;
        end
      end
      if (i == 30) hold = bus.pt_out;
    end
    check("b2b_t1", 128'(t1), 128'd21);
    check("b2b_t2", 128'(t2), 128'd43);
    check("b2b_p1", p1, C1_PT);
    check("b2b_p2", p2, B_PT);
    check("b2b_hold", hold, C1_PT);

    // asynchronous reset in the middle of a block
    @(negedge clk);
    bus.key_in = C1_KEY;
    bus.ct_in = C1_CT;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 128'(bus.busy), 128'h1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(bus.busy), 128'h0);
    check("mid_rst_done", 128'(bus.done), 128'h0);
    check("mid_rst_pt", bus.pt_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("mid_no_done", 128'(ndone), 128'h0);
    do_op(C1_KEY, C1_CT, p, lat, k10, b);
    check("mid_rerun_pt", p, C1_PT);
    check("mid_rerun_latency", 128'(lat), 128'd21);

    // start already high when reset releases
    @(negedge clk);
    rst = 1'b1;
    bus.key_in = B_KEY;
    bus.ct_in = B_CT;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rel_busy", 128'(bus.busy), 128'h1);
    wait_done(p, lat, k10, b);
    check("rel_pt", p, B_PT);
    check("rel_latency", 128'(lat), 128'd21);

    for (int n = 0; n < 100; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_op(key, encrypt(key, pt), p, lat, k10, b);
      check($sformatf("rt%0d_pt", n), p, pt);
      check($sformatf("rt%0d_rk_init", n), k10, round_key(key, 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
